// File: rtl/swap_reg_ctrl.sv
// Sequencing controller for the three-register swap datapath: accepts MOVE/SWAP
// commands and steps the bus mux select and register load enables.
module swap_reg_ctrl #(
  parameter int TEMP_IDX = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [1:0] cmd_src,
  input  logic [1:0] cmd_dst,
  output logic [1:0] s,
  output logic [2:0] ld,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] TEMP_SEL = 2'(TEMP_IDX);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MV   = 3'd1;
  localparam logic [2:0] ST_SW1  = 3'd2;
  localparam logic [2:0] ST_SW2  = 3'd3;
  localparam logic [2:0] ST_SW3  = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  logic [2:0] state_q, state_d;
  logic [1:0] src_q, src_d;
  logic [1:0] dst_q, dst_d;
  logic       illegal;

  // Register index 1..3 to its one-hot load enable; index 0 (data_in) loads nothing.
  function automatic logic [2:0] dec_ld(input logic [1:0] idx);
    case (idx)
      2'd1:    dec_ld = 3'b001;
      2'd2:    dec_ld = 3'b010;
      2'd3:    dec_ld = 3'b100;
      default: dec_ld = 3'b000;
    endcase
  endfunction

  always_comb begin
    if (cmd_op) begin
      illegal = (cmd_src == 2'd0) || (cmd_dst == 2'd0) ||
                (cmd_src == TEMP_SEL) || (cmd_dst == TEMP_SEL) ||
                (cmd_src == cmd_dst);
    end else begin
      illegal = (cmd_dst == 2'd0);
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          src_d = cmd_src;
          dst_d = cmd_dst;
          if (illegal)     state_d = ST_ERR;
          else if (cmd_op) state_d = ST_SW1;
          else             state_d = ST_MV;
        end
      end
      ST_MV:   state_d = ST_DONE;
      ST_SW1:  state_d = ST_SW2;
      ST_SW2:  state_d = ST_SW3;
      ST_SW3:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      src_q   <= 2'd0;
      dst_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
    end
  end

  // SWAP rotates a -> temp, b -> a, temp -> b with a = src and b = dst.
  always_comb begin
    s         = 2'd0;
    ld        = 3'b000;
    done      = 1'b0;
    err       = 1'b0;
    cmd_ready = (state_q == ST_IDLE);
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_MV: begin
        s  = src_q;
        ld = dec_ld(dst_q);
      end
      ST_SW1: begin
        s  = src_q;
        ld = dec_ld(TEMP_SEL);
      end
      ST_SW2: begin
        s  = dst_q;
        ld = dec_ld(src_q);
      end
      ST_SW3: begin
        s  = TEMP_SEL;
        ld = dec_ld(dst_q);
      end
      ST_DONE: done = 1'b1;
      ST_ERR:  err  = 1'b1;
      default: ;
    endcase
  end

endmodule
